pixel_stream_gen: RTL and testbench

- Raster pixel-stream source that drives the camera-side stream interface: iDATA/iDVAL/iX_Cont/iY_Cont into the convolution/filter blocks.
- Produces frames of 12-bit pixels with X/Y coordinates, line/frame valid flags, horizontal/vertical blanking and stall gaps.
- Selectable test patterns.
- Used as a CCD-capture substitute for bring-up and as the stimulus source in filter benches.

---
 rtl/pixel_stream_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_pixel_stream_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_gen.sv
// Raster pixel-stream source: emits frames of 12-bit test-pattern pixels with
// X/Y coordinates, LVAL/FVAL framing, horizontal/vertical blanking and stall gaps.
module pixel_stream_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_BLANK  = 4,
  parameter int unsigned CHK_LOG2 = 3,
  localparam int unsigned PIX_W   = 12,
  localparam int unsigned COORD_W = 11,
  localparam int unsigned FCNT_W  = 16
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic               iSTOP,
  input  logic               iSTALL,
  input  logic [1:0]         iMODE,
  input  logic [PIX_W-1:0]   iCONST,
  output logic [PIX_W-1:0]   oDATA,
  output logic               oDVAL,
  output logic [COORD_W-1:0] oX_Cont,
  output logic [COORD_W-1:0] oY_Cont,
  output logic               oLVAL,
  output logic               oFVAL,
  output logic [FCNT_W-1:0]  oFRAME_CNT,
  output logic               oBUSY
);

  // A blank line lasts as long as a full active line plus its horizontal blank
  localparam int unsigned VB_CYC  = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int unsigned VB_LAST = (VB_CYC == 0) ? 0 : VB_CYC - 1;
  localparam int unsigned CNT_MAX = (VB_CYC > H_BLANK) ? VB_CYC : H_BLANK;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit          VB_SKIP = (V_BLANK == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] px, py, px_nxt, py_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [PIX_W-1:0]   const_q, const_nxt;
  logic               stop_pend, stop_nxt;

  logic [PIX_W-1:0]   data_nxt;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic [FCNT_W-1:0]  fcnt_nxt;
  logic               dval_nxt, lval_nxt, fval_nxt, busy_nxt;

  logic start_c, line_end_c, last_line_c, hb_done_c, vb_done_c;
  logic stop_now_c, restart_c, new_frame_c;

  // Pixel value for the selected pattern at coordinate (x, y)
  function automatic logic [PIX_W-1:0] pattern(input logic [1:0]         m,
                                               input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y,
                                               input logic [PIX_W-1:0]   c);
    logic [PIX_W-1:0] v;
    case (m)
      2'd0:    v = {1'b0, x};
      2'd1:    v = {1'b0, y};
      2'd2:    v = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      default: v = c;
    endcase
    return v;
  endfunction

  // Shared decode of frame/line boundary events
  assign start_c     = (state == S_IDLE) && iSTART;
  assign line_end_c  = (state == S_ACTIVE) && !iSTALL && (px == COORD_W'(H_ACTIVE - 1));
  assign last_line_c = (py == COORD_W'(V_ACTIVE - 1));
  assign hb_done_c   = (state == S_HBLANK) && (cnt == CNT_W'(H_BLANK - 1));
  assign vb_done_c   = ((state == S_VBLANK) && (cnt == CNT_W'(VB_LAST))) ||
                       (VB_SKIP && hb_done_c && last_line_c);
  assign stop_now_c  = stop_pend | iSTOP;
  assign restart_c   = vb_done_c && !stop_now_c;
  assign new_frame_c = start_c || restart_c;

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (iSTART) state_nxt = S_ACTIVE;
      S_ACTIVE: if (line_end_c) state_nxt = S_HBLANK;
      S_HBLANK: begin
        if (hb_done_c) begin
          if (!last_line_c)  state_nxt = S_ACTIVE;
          else if (!VB_SKIP) state_nxt = S_VBLANK;
        end
      end
      default: ;
    endcase
    // End of vertical blank (or of the last line when there is none)
    if (vb_done_c) state_nxt = stop_now_c ? S_IDLE : S_ACTIVE;
  end

  // Next values of the outputs, pixel pointer, blank counter and frame latches
  always_comb begin
    data_nxt  = oDATA;
    dval_nxt  = 1'b0;
    x_nxt     = oX_Cont;
    y_nxt     = oY_Cont;
    lval_nxt  = 1'b0;
    fval_nxt  = oFVAL;
    fcnt_nxt  = oFRAME_CNT;
    busy_nxt  = oBUSY;
    px_nxt    = px;
    py_nxt    = py;
    cnt_nxt   = '0;
    mode_nxt  = mode_q;
    const_nxt = const_q;
    stop_nxt  = stop_pend;

    if ((state != S_IDLE) && iSTOP) stop_nxt = 1'b1;

    case (state)
      S_ACTIVE: begin
        lval_nxt = 1'b1;
        if (!iSTALL) begin
          dval_nxt = 1'b1;
          data_nxt = pattern(mode_q, px, py, const_q);
          x_nxt    = px;
          y_nxt    = py;
          if (line_end_c) begin
            px_nxt = '0;
            if (last_line_c) fval_nxt = 1'b0;
          end else begin
            px_nxt = px + COORD_W'(1);
          end
        end
      end
      S_HBLANK: begin
        if (!hb_done_c) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else if (!last_line_c) begin
          py_nxt = py + COORD_W'(1);
          px_nxt = '0;
        end else begin
          fcnt_nxt = oFRAME_CNT + FCNT_W'(1);
        end
      end
      S_VBLANK: begin
        if (!vb_done_c) cnt_nxt = cnt + CNT_W'(1);
      end
      default: ;
    endcase

    // Stream ends after the blanking of a frame with a stop request
    if (vb_done_c && stop_now_c) begin
      busy_nxt = 1'b0;
      x_nxt    = '0;
      y_nxt    = '0;
      stop_nxt = 1'b0;
    end

    // Frame start: latch pattern controls and present (0,0) on this edge
    if (new_frame_c) begin
      mode_nxt  = iMODE;
      const_nxt = iCONST;
      busy_nxt  = 1'b1;
      lval_nxt  = 1'b1;
      px_nxt    = '0;
      py_nxt    = '0;
      if (start_c) stop_nxt = iSTOP;
      if (!iSTALL) begin
        dval_nxt = 1'b1;
        data_nxt = pattern(iMODE, COORD_W'(0), COORD_W'(0), iCONST);
        x_nxt    = '0;
        y_nxt    = '0;
        fval_nxt = 1'b1;
        px_nxt   = COORD_W'(1);
      end
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA      <= '0;
      oDVAL      <= 1'b0;
      oX_Cont    <= '0;
      oY_Cont    <= '0;
      oLVAL      <= 1'b0;
      oFVAL      <= 1'b0;
      oFRAME_CNT <= '0;
      oBUSY      <= 1'b0;
      px         <= '0;
      py         <= '0;
      cnt        <= '0;
      mode_q     <= '0;
      const_q    <= '0;
      stop_pend  <= 1'b0;
    end else begin
      oDATA      <= data_nxt;
      oDVAL      <= dval_nxt;
      oX_Cont    <= x_nxt;
      oY_Cont    <= y_nxt;
      oLVAL      <= lval_nxt;
      oFVAL      <= fval_nxt;
      oFRAME_CNT <= fcnt_nxt;
      oBUSY      <= busy_nxt;
      px         <= px_nxt;
      py         <= py_nxt;
      cnt        <= cnt_nxt;
      mode_q     <= mode_nxt;
      const_q    <= const_nxt;
      stop_pend  <= stop_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen with a 4x3 frame, 2-cycle HBLANK and one blank line.
module tb_pixel_stream_gen;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iSTART = 1'b0;
  logic        iSTOP = 1'b0;
  logic        iSTALL = 1'b0;
  logic [1:0]  iMODE = 2'd0;
  logic [11:0] iCONST = 12'h000;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic        oLVAL;
  logic        oFVAL;
  logic [15:0] oFRAME_CNT;
  logic        oBUSY;

  int checks = 0;
  int failures = 0;

  pixel_stream_gen #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_BLANK(1), .CHK_LOG2(1)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP), .iSTALL(iSTALL),
    .iMODE(iMODE), .iCONST(iCONST), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oLVAL(oLVAL), .oFVAL(oFVAL),
    .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Advance one clock and settle just after the active edge
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      iSTART = ~iSTART; iSTOP = ~iSTOP; iSTALL = ~iSTALL;
      iMODE = iMODE + 2'd1; iCONST = iCONST + 12'h111;
      checks++;
      if ({oDATA, oDVAL, oX_Cont, oY_Cont, oLVAL, oFVAL, oFRAME_CNT, oBUSY} !== 54'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d data=%h dval=%b x=%0d y=%0d lval=%b fval=%b fcnt=%0d busy=%b expected all 0",
                 i, oDATA, oDVAL, oX_Cont, oY_Cont, oLVAL, oFVAL, oFRAME_CNT, oBUSY);
      end
    end
    iSTART = 0; iSTOP = 0; iSTALL = 0; iMODE = 0; iCONST = 0;
    #3 iRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({oDATA, oDVAL, oX_Cont, oY_Cont, oLVAL, oFVAL, oFRAME_CNT, oBUSY} !== 54'd0) begin
        failures++;
        $display("FAIL reset_release_idle cyc=%0d dval=%b busy=%b data=%h expected all 0",
                 i, oDVAL, oBUSY, oDATA);
      end
    end
  endtask

  task automatic test_frame_stop();
    iMODE = 2'd0; iSTART = 1'b1; iSTOP = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic e_dv, e_fval, e_busy;
      logic [15:0] e_fcnt;
      step();
      if (k == 0) begin iSTART = 1'b0; iSTOP = 1'b0; end
      e_dv   = (k < 18) && ((k % 6) < 4);
      e_fval = (k < 15);
      e_busy = (k < 23);
      e_fcnt = (k >= 17) ? 16'd1 : 16'd0;
      checks++;
      if (oDVAL !== e_dv) begin
        failures++; $display("FAIL stop_dval k=%0d got=%b exp=%b", k, oDVAL, e_dv);
      end
      checks++;
      if (oLVAL !== e_dv) begin
        failures++; $display("FAIL stop_lval k=%0d got=%b exp=%b", k, oLVAL, e_dv);
      end
      checks++;
      if (oFVAL !== e_fval) begin
        failures++; $display("FAIL stop_fval k=%0d got=%b exp=%b", k, oFVAL, e_fval);
      end
      checks++;
      if (oBUSY !== e_busy) begin
        failures++; $display("FAIL stop_busy k=%0d got=%b exp=%b", k, oBUSY, e_busy);
      end
      checks++;
      if (oFRAME_CNT !== e_fcnt) begin
        failures++; $display("FAIL stop_fcnt k=%0d got=%0d exp=%0d", k, oFRAME_CNT, e_fcnt);
      end
      if (e_dv) begin
        checks++;
        if (oDATA !== 12'(k % 6) || oX_Cont !== 11'(k % 6) || oY_Cont !== 11'(k / 6)) begin
          failures++;
          $display("FAIL stop_pixel k=%0d got data=%h x=%0d y=%0d exp data=%h x=%0d y=%0d",
                   k, oDATA, oX_Cont, oY_Cont, 12'(k % 6), k % 6, k / 6);
        end
      end
      if (k == 23) begin
        checks++;
        if (oX_Cont !== 11'd0 || oY_Cont !== 11'd0) begin
          failures++; $display("FAIL stop_coord_clear got x=%0d y=%0d exp 0 0", oX_Cont, oY_Cont);
        end
      end
    end
    step();
    checks++;
    if (oDVAL !== 1'b0 || oBUSY !== 1'b0) begin
      failures++; $display("FAIL stop_stays_idle got dval=%b busy=%b exp 0 0", oDVAL, oBUSY);
    end
  endtask

  task automatic test_stall();
    logic       e_dv[7]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] e_pix[7]  = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
    int n = 0;
    iMODE = 2'd0; iSTART = 1'b1; iSTOP = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      n += int'(oDVAL);
      checks++;
      if (oDVAL !== e_dv[k]) begin
        failures++; $display("FAIL stall_dval k=%0d got=%b exp=%b", k, oDVAL, e_dv[k]);
      end
      checks++;
      if (oDATA !== 12'(e_pix[k]) || oX_Cont !== 11'(e_pix[k]) || oY_Cont !== 11'd0) begin
        failures++;
        $display("FAIL stall_pixel k=%0d got data=%h x=%0d y=%0d exp data=%h x=%0d y=0",
                 k, oDATA, oX_Cont, oY_Cont, 12'(e_pix[k]), e_pix[k]);
      end
      checks++;
      if (oLVAL !== 1'b1 || oFVAL !== 1'b1) begin
        failures++; $display("FAIL stall_lval k=%0d got lval=%b fval=%b exp 1 1", k, oLVAL, oFVAL);
      end
      if (k == 0) iSTART = 1'b0;
      if (k == 1) iSTALL = 1'b1;
      if (k == 4) iSTALL = 1'b0;
    end
    step();
    checks++;
    if (oDVAL !== 1'b0 || oLVAL !== 1'b0) begin
      failures++; $display("FAIL stall_hblank got dval=%b lval=%b exp 0 0", oDVAL, oLVAL);
    end
    iSTOP = 1'b1;
    step();
    iSTOP = 1'b0;
    n += int'(oDVAL);
    for (int i = 0; i < 60 && oBUSY; i++) begin
      step();
      n += int'(oDVAL);
    end
    checks++;
    if (oBUSY !== 1'b0) begin
      failures++; $display("FAIL stall_timeout busy still %b after 60 cycles exp 0", oBUSY);
    end
    checks++;
    if (n != 12) begin
      failures++; $display("FAIL stall_pixel_count got=%0d exp=12", n);
    end
    checks++;
    if (oFRAME_CNT !== 16'd2) begin
      failures++; $display("FAIL stall_fcnt got=%0d exp=2", oFRAME_CNT);
    end
  endtask

  task automatic test_continuous();
    iMODE = 2'd1; iSTART = 1'b1; iSTOP = 1'b0;
    for (int g = 0; g < 47; g++) begin
      int k;
      logic e_dv;
      logic [15:0] e_fcnt;
      step();
      k = (g >= 23) ? g - 23 : g;
      e_dv = (k < 18) && ((k % 6) < 4);
      e_fcnt = (g < 17) ? 16'd2 : (g < 40) ? 16'd3 : 16'd4;
      checks++;
      if (oDVAL !== e_dv) begin
        failures++; $display("FAIL cont_dval g=%0d got=%b exp=%b", g, oDVAL, e_dv);
      end
      if (e_dv) begin
        checks++;
        if (oDATA !== 12'(k / 6) || oY_Cont !== 11'(k / 6) || oX_Cont !== 11'(k % 6)) begin
          failures++;
          $display("FAIL cont_pixel g=%0d got data=%h x=%0d y=%0d exp data=%h x=%0d y=%0d",
                   g, oDATA, oX_Cont, oY_Cont, 12'(k / 6), k % 6, k / 6);
        end
      end
      checks++;
      if (oBUSY !== (g != 46)) begin
        failures++; $display("FAIL cont_busy g=%0d got=%b exp=%b", g, oBUSY, g != 46);
      end
      checks++;
      if (oFRAME_CNT !== e_fcnt) begin
        failures++; $display("FAIL cont_fcnt g=%0d got=%0d exp=%0d", g, oFRAME_CNT, e_fcnt);
      end
      if (g == 23) begin
        checks++;
        if (oFVAL !== 1'b1 || oLVAL !== 1'b1) begin
          failures++; $display("FAIL cont_restart_flags got fval=%b lval=%b exp 1 1", oFVAL, oLVAL);
        end
      end
      if (g == 0) iSTART = 1'b0;
      iSTOP = (g == 30);
    end
    iSTOP = 1'b0;
  endtask

  task automatic test_modes();
    logic [11:0] chk_r0[4] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF};
    logic [11:0] chk_r2[4] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000};
    iMODE = 2'd2; iCONST = 12'hABC; iSTART = 1'b1; iSTOP = 1'b0;
    for (int g = 0; g < 47; g++) begin
      int k;
      logic e_dv;
      logic [11:0] e_data;
      step();
      k = (g >= 23) ? g - 23 : g;
      e_dv = (k < 18) && ((k % 6) < 4);
      if (g >= 23)          e_data = 12'hABC;
      else if (k / 6 == 2)  e_data = chk_r2[k % 6];
      else                  e_data = chk_r0[k % 6];
      if (e_dv) begin
        checks++;
        if (oDATA !== e_data) begin
          failures++;
          $display("FAIL mode_data g=%0d x=%0d y=%0d got=%h exp=%h", g, k % 6, k / 6, oDATA, e_data);
        end
      end
      if (g == 0) iSTART = 1'b0;
      if (g == 5) iMODE = 2'd3;
      if (g == 25) iCONST = 12'h123;
      iSTOP = (g == 30);
    end
    iSTOP = 1'b0;
    checks++;
    if (oBUSY !== 1'b0 || oFRAME_CNT !== 16'd6) begin
      failures++; $display("FAIL mode_end got busy=%b fcnt=%0d exp busy=0 fcnt=6", oBUSY, oFRAME_CNT);
    end
  endtask

  task automatic test_async_reset();
    iMODE = 2'd0; iSTART = 1'b1; iSTOP = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) iSTART = 1'b0;
    end
    checks++;
    if (oDVAL !== 1'b1 || oX_Cont !== 11'd1 || oY_Cont !== 11'd1) begin
      failures++; $display("FAIL areset_pre got dval=%b x=%0d y=%0d exp 1 1 1", oDVAL, oX_Cont, oY_Cont);
    end
    #2 iRST = 1'b0;
    #1;
    checks++;
    if ({oDATA, oDVAL, oX_Cont, oY_Cont, oLVAL, oFVAL, oBUSY} !== 38'd0) begin
      failures++;
      $display("FAIL areset_outputs got data=%h dval=%b x=%0d y=%0d lval=%b fval=%b busy=%b exp all 0",
               oDATA, oDVAL, oX_Cont, oY_Cont, oLVAL, oFVAL, oBUSY);
    end
    checks++;
    if (oFRAME_CNT !== 16'd0) begin
      failures++; $display("FAIL areset_fcnt got=%0d exp=0", oFRAME_CNT);
    end
    #3 iRST = 1'b1;
    iSTART = 1'b1; iSTOP = 1'b1; iMODE = 2'd0;
    step();
    iSTART = 1'b0; iSTOP = 1'b0;
    checks++;
    if (oDVAL !== 1'b1 || oX_Cont !== 11'd0 || oY_Cont !== 11'd0 || oDATA !== 12'h000 || oBUSY !== 1'b1) begin
      failures++;
      $display("FAIL areset_restart got dval=%b x=%0d y=%0d data=%h busy=%b exp 1 0 0 000 1",
               oDVAL, oX_Cont, oY_Cont, oDATA, oBUSY);
    end
    for (int i = 0; i < 60 && oBUSY; i++) step();
    checks++;
    if (oBUSY !== 1'b0 || oFRAME_CNT !== 16'd1) begin
      failures++; $display("FAIL areset_frame got busy=%b fcnt=%0d exp busy=0 fcnt=1", oBUSY, oFRAME_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_frame_stop();
    test_stall();
    test_continuous();
    test_modes();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on simulation time
  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
